// File: rtl/sdram_slot_arbiter.sv
// rtl/sdram_slot_arbiter.sv - two-port request arbiter and slot aligner for the 8-phase SDRAM controller
// SDRAM_ARB_RR_EN defined: round-robin between ports when both pend; undefined: fixed A over B.
module sdram_slot_arbiter #(
  parameter int ADDR_W      = 22,
  parameter int CAPTURE_DLY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkref,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [1:0]        a_ds,
  input  logic [15:0]       a_wdata,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [1:0]        b_ds,
  input  logic [15:0]       b_wdata,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  output logic              sd_oe,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [1:0]        sd_ds,
  output logic [15:0]       sd_din,
  input  logic [15:0]       sd_dout
);

  typedef enum logic [1:0] {IDLE, ARM, BUSY, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       ref_q;
  logic       rise, fall;
  logic       grant, capture, slot_end;
  logic       sel_b, sel_we;
  logic       gnt_b;
`ifdef SDRAM_ARB_RR_EN
  logic       rr_last;
`endif

  assign rise = clkref & ~ref_q;
  assign fall = ~clkref & ref_q;

`ifdef SDRAM_ARB_RR_EN
  // rr_last=1 means B won the previous contested or uncontested grant, so A goes next
  assign sel_b = b_req & (~a_req | ~rr_last);
`else
  assign sel_b = b_req & ~a_req;
`endif
  assign sel_we = sel_b ? b_we : a_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant    = 1'b0;
    capture  = 1'b0;
    slot_end = 1'b0;
    case (state)
      IDLE, DONE: begin
        // slot boundary: close the finished slot and immediately arbitrate the next one
        if (fall) begin
          slot_end = (state == DONE);
          if (a_req | b_req) begin
            grant    = 1'b1;
            state_nx = ARM;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      ARM: begin
        if (rise) begin
          cnt_nx   = 3'd1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 3'(CAPTURE_DLY)) begin
          capture  = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q   <= 1'b0;
      gnt_b   <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= 16'd0;
      b_rdata <= 16'd0;
      sd_oe   <= 1'b0;
      sd_we   <= 1'b0;
      sd_addr <= '0;
      sd_ds   <= 2'd0;
      sd_din  <= 16'd0;
`ifdef SDRAM_ARB_RR_EN
      rr_last <= 1'b1;
`endif
    end else begin
      ref_q <= clkref;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      if (slot_end) begin
        sd_oe <= 1'b0;
        sd_we <= 1'b0;
      end
      // a new grant overrides the slot-end drop in the same cycle
      if (grant) begin
        gnt_b   <= sel_b;
        sd_we   <= sel_we;
        sd_oe   <= ~sel_we;
        sd_addr <= sel_b ? b_addr  : a_addr;
        sd_ds   <= sel_b ? b_ds    : a_ds;
        sd_din  <= sel_b ? b_wdata : a_wdata;
`ifdef SDRAM_ARB_RR_EN
        rr_last <= sel_b;
`endif
      end
      if (capture) begin
        if (gnt_b) begin
          b_ack <= 1'b1;
          if (!sd_we) b_rdata <= sd_dout;
        end else begin
          a_ack <= 1'b1;
          if (!sd_we) a_rdata <= sd_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb/tb_sdram_slot_arbiter.sv - self-checking bench for sdram_slot_arbiter
module tb_sdram_slot_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clkref = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [21:0] a_addr = '0;
  logic [1:0]  a_ds = '0;
  logic [15:0] a_wdata = '0;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [21:0] b_addr = '0;
  logic [1:0]  b_ds = '0;
  logic [15:0] b_wdata = '0;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        sd_oe, sd_we;
  logic [21:0] sd_addr;
  logic [1:0]  sd_ds;
  logic [15:0] sd_din;
  logic [15:0] sd_dout = 16'hDEAD;

  int total = 0;
  int bad = 0;
  int ph = 0;

  logic [15:0] sdram  [bit [21:0]];
  logic [15:0] shadow [bit [21:0]];

  typedef struct {
    bit          b;
    bit          we;
    logic [21:0] addr;
    logic [1:0]  ds;
    logic [15:0] wdata;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    bit          v;
    bit          b;
    bit          we;
    logic [21:0] addr;
    logic [1:0]  ds;
    logic [15:0] wdata;
  } txn_t;

  sdram_slot_arbiter dut (
    .clk(clk), .reset(reset), .clkref(clkref),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_ds(a_ds), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_ds(b_ds), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_ds(sd_ds), .sd_din(sd_din),
    .sd_dout(sd_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] ds,
                                        input logic [15:0] d);
    return {ds[1] ? d[15:8] : old[15:8], ds[0] ? d[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] sdram_rd(input logic [21:0] a);
    return sdram.exists(a) ? sdram[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] shadow_rd(input logic [21:0] a);
    return shadow.exists(a) ? shadow[a] : 16'h0000;
  endfunction

  // Controller model: ph counts clk phases, clkref low on ph 0..1 and high on 2..7,
  // read data valid only at phase 5 after the clkref rise, writes commit at that phase too.
  always @(posedge clk) begin
    if (sd_we && ph == 7) sdram[sd_addr] = merge(sdram_rd(sd_addr), sd_ds, sd_din);
    #2;
    ph = (ph + 1) % 8;
    clkref = (ph >= 2);
    sd_dout = (ph == 7) ? sdram_rd(sd_addr) : 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_ph(input int p);
    bit ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ph == p) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_phase_timeout", 0, 1);
  endtask

  task automatic drive(input bit b, input bit req, input bit we, input logic [21:0] addr,
                       input logic [1:0] ds, input logic [15:0] wd);
    if (b) begin
      b_req = req; b_we = we; b_addr = addr; b_ds = ds; b_wdata = wd;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_ds = ds; a_wdata = wd;
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk(nm, {a_ack, b_ack, sd_oe, sd_we, sd_ds, a_rdata, b_rdata, sd_din, sd_addr}, '0);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int slot_len = 0, ack_n = 0, oth_n = 0, bad_f = 0, lat = -1;
    bit seen = 1'b0;
    logic [15:0] other_rd;
    wait_ph(3);
    other_rd = v.b ? a_rdata : b_rdata;
    drive(v.b, 1'b1, v.we, v.addr, v.ds, v.wdata);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (sd_oe | sd_we) begin
        seen = 1'b1;
        slot_len++;
        if ({sd_oe, sd_we, sd_addr, sd_ds, sd_din} !== {~v.we, v.we, v.addr, v.ds, v.wdata}) bad_f++;
      end
      if (v.b ? b_ack : a_ack) begin
        ack_n++;
        lat = t;
        drive(v.b, 1'b0, v.we, v.addr, v.ds, v.wdata);
      end
      if (v.b ? a_ack : b_ack) oth_n++;
      if (seen && !(sd_oe | sd_we)) break;
    end
    chk({nm, "_ack_once"}, ack_n, 1);
    chk({nm, "_other_ack"}, oth_n, 0);
    chk({nm, "_slot_len"}, slot_len, 8);
    chk({nm, "_fields_stable"}, bad_f, 0);
    chk({nm, "_latency_le_16"}, (lat >= 0 && lat <= 16), 1);
    chk({nm, "_other_rdata_held"}, v.b ? a_rdata : b_rdata, other_rd);
    if (!v.we) chk({nm, "_rdata"}, v.b ? b_rdata : a_rdata, v.rd);
  endtask

  function automatic bit pick_b(input bit a, input bit b, input bit last_b);
    bit rr = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    rr = 1'b1;
`endif
    if (a && b) return rr && !last_b;
    return b;
  endfunction

  task automatic rand_test(input int periods);
    txn_t cur, nx;
    int errs = 0, acks = 0;
    bit last_b = 1'b1;
    cur = '{default: '0};
    nx = '{default: '0};
    for (int i = 0; i < periods * 8; i++) begin
      @(negedge clk);
      if (cur.v) begin
        if ({sd_oe, sd_we, sd_addr, sd_ds, sd_din} !== {~cur.we, cur.we, cur.addr, cur.ds, cur.wdata})
          errs++;
      end else if (sd_oe | sd_we) errs++;
      if (ph == 0 && cur.v) begin
        if ({a_ack, b_ack} !== (cur.b ? 2'b01 : 2'b10)) errs++;
        else acks++;
        if (!cur.we) begin
          if ((cur.b ? b_rdata : a_rdata) !== shadow_rd(cur.addr)) errs++;
        end else begin
          shadow[cur.addr] = merge(shadow_rd(cur.addr), cur.ds, cur.wdata);
        end
        if (cur.b) b_req = 1'b0;
        else a_req = 1'b0;
      end else if (a_ack | b_ack) errs++;
      for (int p = 0; p < 2; p++) begin
        if (!(p ? b_req : a_req) && $urandom_range(3) == 0)
          drive(p[0], 1'b1, 1'($urandom_range(1)), 22'h100 + 22'($urandom_range(7)),
                2'($urandom_range(3)), 16'($urandom));
      end
      if (ph == 0) begin
        nx.v = a_req | b_req;
        if (nx.v) begin
          nx.b = pick_b(a_req, b_req, last_b);
          nx.we = nx.b ? b_we : a_we;
          nx.addr = nx.b ? b_addr : a_addr;
          nx.ds = nx.b ? b_ds : a_ds;
          nx.wdata = nx.b ? b_wdata : a_wdata;
          last_b = nx.b;
        end
        cur = nx;
      end
    end
    chk("rand_errors", errs, 0);
    chk("rand_enough_acks", acks > periods / 2, 1);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] seq;
    int n_ack, dual, early, regrant;
    bit prev_oe, seen;
    vecs[0] = '{1'b0, 1'b0, 22'h012345, 2'b11, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 22'h3FFFFF, 2'b10, 16'h55AA, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 22'h3FFFFF, 2'b11, 16'h0000, 16'h5500};
    vecs[3] = '{1'b0, 1'b1, 22'h000000, 2'b01, 16'h1234, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 22'h000000, 2'b11, 16'h0000, 16'h0034};
    vecs[5] = '{1'b1, 1'b0, 22'h012345, 2'b11, 16'h0000, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b1, 22'h012345, 2'b11, 16'hCAFE, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 22'h012345, 2'b11, 16'h0000, 16'hCAFE};
    sdram[22'h012345] = 16'hBEEF;

    do_reset("reset_outputs_zero");
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // both ports held for four periods
    do_reset("reset_clears_rdata");
    wait_ph(3);
    drive(1'b0, 1'b1, 1'b0, 22'h000010, 2'b11, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 22'h000020, 2'b11, 16'h0);
    wait_ph(0);
    seq = '0; n_ack = 0; dual = 0;
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      if (a_ack & b_ack) dual++;
      if (a_ack | b_ack) begin
        seq = {seq[6:0], b_ack};
        n_ack++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk("contend_ack_count", n_ack, 4);
    chk("contend_dual_ack", dual, 0);
`ifdef SDRAM_ARB_RR_EN
    chk("contend_order_rr", seq[3:0], 4'b0101);
`else
    chk("contend_order_fixed", seq[3:0], 4'b0000);
`endif

    // reset in the middle of a read slot
    do_reset("reset_before_midslot");
    wait_ph(3);
    drive(1'b0, 1'b1, 1'b0, 22'h012345, 2'b11, 16'h0);
    wait_ph(0);
    wait_ph(5);
    chk("midrst_granted", sd_oe, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_oe_ack_drop", {sd_oe, sd_we, a_ack, b_ack}, 4'b0000);
    reset = 1'b0;
    n_ack = 0; early = 0; seen = 1'b0;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (sd_oe) seen = 1'b1;
      if (a_ack) begin
        n_ack++;
        if (!seen) early++;
        a_req = 1'b0;
      end
    end
    chk("midrst_no_stale_ack", early, 0);
    chk("midrst_regrant_ack", n_ack, 1);
    chk("midrst_rdata", a_rdata, 16'hCAFE);

    // idle periods, then a mid-period request
    n_ack = 0;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (sd_oe | sd_we | a_ack | b_ack) n_ack++;
    end
    chk("idle_quiet", n_ack, 0);
    run_vec('{1'b0, 1'b0, 22'h3FFFFF, 2'b11, 16'h0, 16'h5500}, "idle_then_a");

    // request dropped right after grant
    wait_ph(3);
    drive(1'b0, 1'b1, 1'b0, 22'h000000, 2'b11, 16'h0);
    seen = 1'b0;
    for (int t = 0; t < 16 && !seen; t++) begin
      @(negedge clk);
      seen = sd_oe;
    end
    chk("drop_granted", seen, 1'b1);
    @(negedge clk);
    a_req = 1'b0;
    n_ack = 0; regrant = 0; prev_oe = sd_oe;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (a_ack) n_ack++;
      if (sd_oe && !prev_oe) regrant++;
      prev_oe = sd_oe;
    end
    chk("drop_ack_once", n_ack, 1);
    chk("drop_no_regrant", regrant, 0);
    chk("drop_rdata", a_rdata, 16'h0034);

    do_reset("reset_before_random");
    rand_test(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
